// File: rtl/epu_pkg.sv
// Shared constants and state type for the EPU verify-job loader.
package epu_pkg;

  localparam int SIGN_W = 512;
  localparam int KEY_W  = 256;
  localparam int HASH_W = 256;
  localparam int JOB_W  = 1024;

  // Loader sequencing states
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } epu_state_e;

  // Number of load words that make up one job
  function automatic int job_words(input int word_w);
    return JOB_W / word_w;
  endfunction

endpackage

// File: rtl/epu_job_shreg.sv
// Job assembly shift register: each accepted word enters at the LSB end and
// older words move up, so the first word of a job lands in the MSBs.
module epu_job_shreg
  import epu_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [WORD_W-1:0] din,
  output logic [JOB_W-1:0]  q
);

  // Shift one word in per accept; a reset discards any partial job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= {q[JOB_W-WORD_W-1:0], din};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/epu_job_loader.sv
// Initiator side of the EPU verify interface. Collects one Ed25519 verify
// job (sign, key, rhash) from a word stream, starts the EPU with a one-cycle
// valid pulse, waits for the rising edge of ready and returns the result.
// Optional build macro EPU_LOADER_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts the job with res_timeout=1 after TIMEOUT_CYCLES cycles.
module epu_job_loader
  import epu_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               axiclk,
  input  logic               resetn,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WORD_W-1:0]  wr_data,
  output logic [SIGN_W-1:0]  sign,
  output logic [KEY_W-1:0]   key,
  output logic [HASH_W-1:0]  rhash,
  output logic               valid,
  input  logic               ready,
  input  logic               result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_pass,
  output logic               res_timeout,
  output logic               busy
);

  localparam int NW    = job_words(WORD_W);
  localparam int CNT_W = $clog2(NW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NW - 1);

  epu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_q_r;
  logic             accept_s;
  logic             rise_s;
  logic             wd_hit_s;
  logic [JOB_W-1:0] job_s;

  // wr_ready is only ever high in LOAD, so this is the LOAD-state accept
  assign accept_s = wr_valid & wr_ready;
  assign rise_s   = ready & ~ready_q_r;

  epu_job_shreg #(
    .WORD_W (WORD_W)
  ) u_shreg (
    .clk   (axiclk),
    .rst_n (resetn),
    .en    (accept_s),
    .din   (wr_data),
    .q     (job_s)
  );

  assign sign  = job_s[JOB_W-1 -: SIGN_W];
  assign key   = job_s[HASH_W +: KEY_W];
  assign rhash = job_s[HASH_W-1:0];

  // Previous ready sample, tracked in every state for edge detection
  always_ff @(posedge axiclk or negedge resetn) begin
    if (!resetn) begin
      ready_q_r <= 1'b0;
    end else begin
      ready_q_r <= ready;
    end
  end

`ifdef EPU_LOADER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            res_timeout_r;

  // A genuine ready edge in the same cycle always wins over the watchdog
  assign wd_hit_s = (state_r == WAIT) && (wd_cnt_r == WD_LAST) && !rise_s;

  // Watchdog: cleared while the job is issued, counts WAIT cycles
  always_ff @(posedge axiclk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      wd_cnt_r <= '0;
    end else if ((state_r == WAIT) && !wd_hit_s) begin
      wd_cnt_r <= wd_cnt_r + WD_W'(1);
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end

  // Timeout flag is raised with the aborted response and drops with res_valid
  always_ff @(posedge axiclk or negedge resetn) begin
    if (!resetn) begin
      res_timeout_r <= 1'b0;
    end else if (wd_hit_s) begin
      res_timeout_r <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_timeout_r <= 1'b0;
    end else begin
      res_timeout_r <= res_timeout_r;
    end
  end

  assign res_timeout = res_timeout_r;
`else
  assign wd_hit_s    = 1'b0;
  assign res_timeout = 1'b0;
`endif

  // Job sequencing: load words, pulse valid, await EPU edge, hand back result
  always_ff @(posedge axiclk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= LOAD;
      cnt_r     <= '0;
      wr_ready  <= 1'b0;
      valid     <= 1'b0;
      res_valid <= 1'b0;
      res_pass  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            busy <= 1'b1;
            if (cnt_r == LAST_CNT) begin
              cnt_r    <= '0;
              wr_ready <= 1'b0;
              valid    <= 1'b1;
              state_r  <= ISSUE;
            end else begin
              cnt_r    <= cnt_r + CNT_W'(1);
              wr_ready <= 1'b1;
            end
          end else begin
            wr_ready <= 1'b1;
          end
        end
        ISSUE: begin
          valid   <= 1'b0;
          state_r <= WAIT;
        end
        WAIT: begin
          if (rise_s) begin
            res_pass  <= result;
            res_valid <= 1'b1;
            state_r   <= RESP;
          end else if (wd_hit_s) begin
            res_pass  <= 1'b0;
            res_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            wr_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= LOAD;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r   <= LOAD;
          cnt_r     <= '0;
          wr_ready  <= 1'b0;
          valid     <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_epu_job_loader.sv
// Self-checking bench for epu_job_loader. Jobs are modelled as an array of
// words; the expected {sign,key,rhash} image is rebuilt from the word-order
// rule (word k at bits 1023-k*WORD_W downward) independently of the RTL.
module tb_epu_job_loader;

  localparam int WORD_W = 32;
  localparam int NW     = 1024 / WORD_W;

  logic              axiclk;
  logic              resetn;
  logic              wr_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] wr_data;
  logic [511:0]      sign;
  logic [255:0]      key;
  logic [255:0]      rhash;
  logic              valid;
  logic              ready;
  logic              result;
  logic              res_valid;
  logic              res_ready;
  logic              res_pass;
  logic              res_timeout;
  logic              busy;

  int vectors;
  int miscompares;

  logic [WORD_W-1:0] words [NW];
  logic [1023:0]     golden;
  logic [1023:0]     exp_job;

  initial axiclk = 1'b0;
  always #5 axiclk = ~axiclk;

  epu_job_loader #(
    .WORD_W         (WORD_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .axiclk      (axiclk),
    .resetn      (resetn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .sign        (sign),
    .key         (key),
    .rhash       (rhash),
    .valid       (valid),
    .ready       (ready),
    .result      (result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_pass    (res_pass),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  // Reference image of a job: word k occupies bits [1023-k*WORD_W -: WORD_W]
  function automatic logic [1023:0] model_job();
    logic [1023:0] j;
    j = '0;
    for (int k = 0; k < NW; k++) j[1023 - k*WORD_W -: WORD_W] = words[k];
    return j;
  endfunction

  task automatic step();
    @(posedge axiclk);
    #1;
  endtask

  task automatic random_words();
    for (int k = 0; k < NW; k++) words[k] = $urandom;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  // Offer words[0..n-1]; gap=1 drops wr_valid every other cycle.
  task automatic load_job(input int n, input bit gap, output int accepts, output int early);
    bit acc;
    accepts = 0;
    early   = 0;
    for (int g = 0; g < 4*NW + 10 && accepts < n; g++) begin
      if (gap && (g % 2 == 1)) begin
        wr_valid = 1'b0;
        wr_data  = $urandom;
      end else begin
        wr_valid = 1'b1;
        wr_data  = words[accepts];
      end
      acc = wr_valid & wr_ready;
      step();
      if (acc) accepts++;
      if (valid && accepts < NW) early++;
    end
    wr_valid = 1'b0;
    wr_data  = $urandom;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #3;
    vectors++;
    if ({wr_ready, valid, res_valid, res_pass, res_timeout, busy} !== 6'b000000)
      $display("FAIL reset_ctrl got=%b exp=000000", {wr_ready, valid, res_valid, res_pass, res_timeout, busy});
    vectors++;
    if ({sign, key, rhash} !== 1024'd0) begin
      miscompares++;
      $display("FAIL reset_data got nonzero job exp=0");
    end
    if ({wr_ready, valid, res_valid, res_pass, res_timeout, busy} !== 6'b000000) miscompares++;
    step();
    step();
    resetn = 1'b1;
    step();
    vectors++;
    if (wr_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release wr_ready=%b busy=%b exp 1/0", wr_ready, busy);
    end
  endtask

  task automatic test_golden();
    int acc, early, bad;
    golden = {
      32'h03e302d5, 32'h1a7c9e44, 32'hb28f6013, 32'h7d44c0a9, 32'he5913b2f, 32'h0c6da871, 32'h94e2f53b, 32'h6b08d1ce,
      32'h2f7a4c95, 32'hd31e0b67, 32'h58c9f2a0, 32'ha4063e1d, 32'h71bd58c2, 32'hc8e4917f, 32'h3f20ad6b, 32'h4b5ea213,
      32'he8325d4a, 32'h90f1c37b, 32'h2ad6e815, 32'h5c73b90e, 32'hf4a81d26, 32'h0b9e57c3, 32'hd7c2a049, 32'h6a4e6380,
      32'h03788934, 32'hbd15f2a8, 32'h46e0c97d, 32'h9a3b51e6, 32'he21f7d04, 32'h5f8c2b93, 32'hc06a48d1, 32'h561313e6};
    for (int k = 0; k < NW; k++) words[k] = golden[1023 - k*WORD_W -: WORD_W];
    load_job(NW, 1'b0, acc, early);
    vectors++;
    if (acc !== NW || early !== 0) begin
      miscompares++;
      $display("FAIL golden_load accepts=%0d early_valid=%0d exp %0d/0", acc, early, NW);
    end
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL golden_issue valid=%b exp=1", valid);
    end
    vectors++;
    if (sign !== golden[1023:512]) begin
      miscompares++;
      $display("FAIL golden_sign got=%h exp=%h", sign, golden[1023:512]);
    end
    vectors++;
    if (key !== golden[511:256]) begin
      miscompares++;
      $display("FAIL golden_key got=%h exp=%h", key, golden[511:256]);
    end
    vectors++;
    if (rhash !== golden[255:0]) begin
      miscompares++;
      $display("FAIL golden_rhash got=%h exp=%h", rhash, golden[255:0]);
    end
    step();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL golden_pulse valid=%b exp=0", valid);
    end
    bad = 0;
    for (int c = 0; c < 49; c++) begin
      if (res_valid || valid || wr_ready || {sign, key, rhash} !== golden) bad++;
      step();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL golden_wait bad_cycles=%0d exp=0", bad);
    end
    ready  = 1'b1;
    result = 1'b1;
    step();
    vectors++;
    if ({res_valid, res_pass, res_timeout, busy} !== 4'b1101) begin
      miscompares++;
      $display("FAIL golden_result got=%b exp=1101", {res_valid, res_pass, res_timeout, busy});
    end
    ready = 1'b0;
    handshake();
    vectors++;
    if ({res_valid, wr_ready, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL golden_done res_valid/wr_ready/busy=%b exp=010", {res_valid, wr_ready, busy});
    end
  endtask

  task automatic test_hold_resp();
    int acc, early, bad;
    random_words();
    exp_job = model_job();
    load_job(NW, 1'b0, acc, early);
    vectors++;
    if (valid !== 1'b1 || {sign, key, rhash} !== exp_job) begin
      miscompares++;
      $display("FAIL hold_issue valid=%b job_ok=%b exp 1/1", valid, ({sign, key, rhash} === exp_job));
    end
    repeat (5) step();
    ready  = 1'b1;
    result = 1'b0;
    step();
    ready  = 1'b0;
    result = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      if (res_valid !== 1'b1 || res_pass !== 1'b0 || wr_ready !== 1'b0) bad++;
      step();
    end
    wr_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_resp bad_cycles=%0d exp=0", bad);
    end
    vectors++;
    if ({sign, key, rhash} !== exp_job) begin
      miscompares++;
      $display("FAIL hold_stable job changed while response pending");
    end
    handshake();
    vectors++;
    if ({wr_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL hold_release wr_ready/res_valid=%b exp=10", {wr_ready, res_valid});
    end
  endtask

  task automatic test_ready_held();
    int acc, early, bad;
    bit r;
    ready = 1'b1;
    do_reset();
    random_words();
    exp_job = model_job();
    load_job(NW, 1'b0, acc, early);
    vectors++;
    if (valid !== 1'b1 || acc !== NW || {sign, key, rhash} !== exp_job) begin
      miscompares++;
      $display("FAIL held_issue valid=%b accepts=%0d exp 1/%0d", valid, acc, NW);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (res_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL held_level captured on a held level, cycles=%0d exp=0", bad);
    end
    ready = 1'b0;
    step();
    r      = 1'($urandom);
    ready  = 1'b1;
    result = r;
    step();
    vectors++;
    if (res_valid !== 1'b1 || res_pass !== r) begin
      miscompares++;
      $display("FAIL held_edge res_valid=%b res_pass=%b exp 1/%b", res_valid, res_pass, r);
    end
    ready = 1'b0;
    handshake();
  endtask

  task automatic test_toggle();
    int acc, early, bad;
    bit r;
    ready = 1'b1;
    step();
    ready = 1'b0;
    random_words();
    exp_job = model_job();
    load_job(NW, 1'b1, acc, early);
    vectors++;
    if (acc !== NW || early !== 0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_load accepts=%0d early=%0d valid=%b exp %0d/0/1", acc, early, valid, NW);
    end
    vectors++;
    if ({sign, key, rhash} !== exp_job) begin
      miscompares++;
      $display("FAIL toggle_data job got=%h exp=%h", sign, exp_job[1023:512]);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (res_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL toggle_stale_edge res_valid cycles=%0d exp=0", bad);
    end
    r      = 1'($urandom);
    ready  = 1'b1;
    result = r;
    step();
    ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b1 || res_pass !== r) begin
      miscompares++;
      $display("FAIL toggle_result res_valid=%b res_pass=%b exp 1/%b", res_valid, res_pass, r);
    end
    handshake();
    vectors++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_wrap busy=%b wr_ready=%b exp 0/1", busy, wr_ready);
    end
  endtask

  task automatic test_reset_midjob();
    int acc, early;
    random_words();
    load_job(20, 1'b0, acc, early);
    vectors++;
    if (acc !== 20 || busy !== 1'b1 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_partial accepts=%0d busy=%b valid=%b exp 20/1/0", acc, busy, valid);
    end
    resetn = 1'b0;
    #2;
    vectors++;
    if ({sign, key, rhash} !== 1024'd0 || busy !== 1'b0 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset busy=%b wr_ready=%b job_zero=%b exp 0/0/1", busy, wr_ready, ({sign, key, rhash} === 1024'd0));
    end
    step();
    resetn = 1'b1;
    step();
    random_words();
    exp_job = model_job();
    load_job(NW, 1'b0, acc, early);
    vectors++;
    if (acc !== NW || early !== 0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reload accepts=%0d early=%0d valid=%b exp %0d/0/1", acc, early, valid, NW);
    end
    vectors++;
    if ({sign, key, rhash} !== exp_job) begin
      miscompares++;
      $display("FAIL mid_data sign got=%h exp=%h", sign, exp_job[1023:512]);
    end
    step();
    ready  = 1'b1;
    result = 1'b1;
    step();
    ready = 1'b0;
    handshake();
  endtask

`ifdef EPU_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int acc, early, cyc;
    ready = 1'b0;
    random_words();
    load_job(NW, 1'b0, acc, early);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 17) begin
      miscompares++;
      $display("FAIL timeout_latency cycles_after_issue=%0d exp=17", cyc);
    end
    vectors++;
    if ({res_valid, res_timeout, res_pass} !== 3'b110) begin
      miscompares++;
      $display("FAIL timeout_flags got=%b exp=110", {res_valid, res_timeout, res_pass});
    end
    handshake();
    vectors++;
    if ({res_valid, res_timeout, wr_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL timeout_clear got=%b exp=001", {res_valid, res_timeout, wr_ready});
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    wr_valid    = 1'b0;
    wr_data     = '0;
    ready       = 1'b0;
    result      = 1'b0;
    res_ready   = 1'b0;
    test_reset();
    test_golden();
    test_hold_resp();
    test_ready_held();
    test_toggle();
    test_reset_midjob();
`ifdef EPU_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/epu_job_loader.md
Name: epu_job_loader

Overview:
- Initiator side of the EPU verify interface; all state runs on the AXI clock domain.
- Assembles one Ed25519 verify job from a stream of 32-bit words: 512-bit sign, 256-bit key, 256-bit rhash.
- Issues the job to EPU with a one-cycle valid pulse, waits for EPU ready, and returns the pass/fail result over a valid/ready result port.

Parameters:
- WORD_W, 32, load-word width; legal values 32 or 64.
- TIMEOUT_CYCLES, 1048576, watchdog limit in axiclk cycles (used only with the optional feature).

Ports:
- axiclk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  load word valid.
- wr_ready  out  1  loader accepts a word.
- wr_data  in  WORD_W  load word, MSB-first order.
- sign  out  512  to EPU.
- key  out  256  to EPU.
- rhash  out  256  to EPU.
- valid  out  1  to EPU; one-cycle job-start pulse.
- ready  in  1  from EPU; a rising edge marks result valid.
- result  in  1  from EPU; 1 = signature good.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_pass  out  1  captured result.
- res_timeout  out  1  job aborted by watchdog (tied 0 when the feature is compiled out).
- busy  out  1  high in any state other than IDLE/LOAD with word count 0.

Behaviour:
- Reset values: all outputs 0; sign/key/rhash are 0; word counter is 0; ready_q (previous ready sample) is 0; state is LOAD.
- NW = 1024/WORD_W words per job.
- Word k fills bits [1023-k*WORD_W -: WORD_W] of the concatenation {sign,key,rhash}. For WORD_W=32: word 0 = sign[511:480], word 15 = sign[31:0], word 16 = key[255:224], word 31 = rhash[31:0].
- LOAD:
  - wr_ready=1; a word is accepted when wr_valid&wr_ready.
  - Counter increments on each accept; on the accept of word NW-1 the counter wraps to 0 and the state goes to ISSUE.
- ISSUE:
  - valid=1 for exactly one cycle; sign/key/rhash are stable from this cycle until the job completes.
  - Next state is WAIT.
- WAIT:
  - wr_ready=0.
  - ready_q tracks ready every cycle in every state.
  - On ready & ~ready_q, capture res_pass<=result and go to RESP.
  - A ready level already high when WAIT is entered is ignored until it falls and rises again.
- RESP:
  - res_valid=1; res_pass is held.
  - On res_valid&res_ready, clear res_valid and return to LOAD in the next cycle.
  - wr_ready stays 0 until then, so at most one job is in flight.
- A ready rising edge outside WAIT is ignored.
- wr_valid with no accept is ignored; data is not required to be held stable while wr_ready=0.
- Asynchronous reset in any state discards the partial job. valid is not re-issued; EPU is reset by the same resetn.
- Throughput: NW load cycles + 1 issue cycle + EPU latency + at least 1 response cycle.

Optional Feature:
- Macro EPU_LOADER_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter clears in ISSUE and increments in WAIT.
  - On reaching TIMEOUT_CYCLES-1 without a ready edge, go to RESP with res_pass=0 and res_timeout=1.
  - res_timeout clears with res_valid.
- Without the macro: no counter is built, res_timeout is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package epu_pkg:
  - Constants SIGN_W=512, KEY_W=256, HASH_W=256, JOB_W=1024.
  - State enum {LOAD, ISSUE, WAIT, RESP}.
- One natural sub-module: epu_job_shreg, a WORD_W-in, JOB_W-out shift register with load-enable. It shifts left by WORD_W on each accept, so word 0 ends up in the MSBs.
- The FSM, edge detect and watchdog stay in the top level.

Test Plan:
- Load the 16 sign words of 03e302d5…5ea213, 8 key words e8325d4a…6a4e6380 and 8 rhash words 03788934…561313e6; EPU model raises ready 50 cycles later with result=1 -> sign/key/rhash match bit-exact, valid high for exactly 1 cycle, res_valid=1, res_pass=1.
- Same job with EPU result=0 and res_ready held low for 10 cycles -> res_valid and res_pass=0 held for all 10 cycles, wr_ready=0 throughout; wr_ready=1 the cycle after the res_ready handshake.
- Ready held high from reset release through the issue of a job -> no capture; capture occurs only on the later low→high transition.
- wr_valid toggled every other cycle during load -> exactly 32 accepts, then ISSUE; the counter wraps to 0.
- Reset asserted after 20 of 32 words, then a full job loaded -> valid issued only after the full 32 new words; outputs contain no stale data.
- With EPU_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ready from EPU -> res_valid at cycle 16 of WAIT with res_timeout=1, res_pass=0.
